// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM port arbiter and its read-tag pipeline.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W          = 20;
    localparam int unsigned DEFAULT_READ_LATENCY = 2;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_IO  = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } read_tag_t;

endpackage

// File: rtl/sram_read_tag_pipe.sv
// Delay line of {valid, owner} tags so returning read data can be routed
// to the requester that issued the address DEPTH cycles earlier.
module sram_read_tag_pipe
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_READ_LATENCY
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_owner,
    output logic out_valid,
    output logic out_owner
);

    read_tag_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= '{valid: in_valid, owner: in_valid ? in_owner : OWNER_CPU};
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_valid = stage_q[DEPTH-1].valid;
    assign out_owner = stage_q[DEPTH-1].owner;

endmodule

// File: rtl/sram_arbiter.sv
// Shares one sramc port between the CPU memory stage and an I/O/loader port:
// fixed CPU priority with a starvation bound for I/O, and tagged read return.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int unsigned READ_LATENCY = DEFAULT_READ_LATENCY,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = SRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_grant,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,

    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [31:0]       io_wdata,
    output logic              io_grant,
    output logic              io_rvalid,
    output logic [31:0]       io_rdata,

    output logic [ADDR_W-1:0] memory_address,
    output logic [31:0]       memory_write,
    output logic              memory_write_enable,
    input  logic [31:0]       memory_read
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    logic       cpu_win, io_win;
    logic       rd_accept, rd_owner;
    logic       tag_valid, tag_owner;

    always_comb begin
        cpu_win = 1'b0;
        io_win  = 1'b0;
        if (!reset) begin
            if (io_req && starve_q == STARVE_MAX) begin
                io_win = 1'b1;
            end else if (cpu_req) begin
                cpu_win = 1'b1;
            end else if (io_req) begin
                io_win = 1'b1;
            end
        end
    end

    assign cpu_grant = cpu_win;
    assign io_grant  = io_win;

    always_comb begin
        memory_address      = '0;
        memory_write        = '0;
        memory_write_enable = 1'b0;
        if (cpu_win) begin
            memory_address      = cpu_addr;
            memory_write        = cpu_wdata;
            memory_write_enable = cpu_we;
        end else if (io_win) begin
            memory_address      = io_addr;
            memory_write        = io_wdata;
            memory_write_enable = io_we;
        end
    end

    // Counts consecutive denied I/O cycles; any grant or dropped request clears it.
    always_comb begin
        starve_d = '0;
        if (io_req && !io_win) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign rd_accept = (cpu_win && !cpu_we) || (io_win && !io_we);
    assign rd_owner  = io_win ? OWNER_IO : OWNER_CPU;

    sram_read_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_accept),
        .in_owner  (rd_owner),
        .out_valid (tag_valid),
        .out_owner (tag_owner)
    );

    assign cpu_rvalid = !reset && tag_valid && (tag_owner == OWNER_CPU);
    assign io_rvalid  = !reset && tag_valid && (tag_owner == OWNER_IO);
    assign cpu_rdata  = cpu_rvalid ? memory_read : 32'd0;
    assign io_rdata   = io_rvalid ? memory_read : 32'd0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_sram_arbiter;
    import sram_pkg::*;

    localparam int unsigned LAT = 2;
    localparam int unsigned LIM = 4;
    localparam int unsigned AW  = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic          io_req = 1'b0, io_we = 1'b0;
    logic [AW-1:0] io_addr = '0;
    logic [31:0]   io_wdata = '0;
    logic          cpu_grant, cpu_rvalid, io_grant, io_rvalid;
    logic [31:0]   cpu_rdata, io_rdata;
    logic [AW-1:0] memory_address;
    logic [31:0]   memory_write;
    logic          memory_write_enable;
    logic [31:0]   memory_read;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_arbiter #(
        .READ_LATENCY (LAT),
        .STARVE_LIMIT (LIM),
        .ADDR_W       (AW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .cpu_req             (cpu_req),
        .cpu_we              (cpu_we),
        .cpu_addr            (cpu_addr),
        .cpu_wdata           (cpu_wdata),
        .cpu_grant           (cpu_grant),
        .cpu_rvalid          (cpu_rvalid),
        .cpu_rdata           (cpu_rdata),
        .io_req              (io_req),
        .io_we               (io_we),
        .io_addr             (io_addr),
        .io_wdata            (io_wdata),
        .io_grant            (io_grant),
        .io_rvalid           (io_rvalid),
        .io_rdata            (io_rdata),
        .memory_address      (memory_address),
        .memory_write        (memory_write),
        .memory_write_enable (memory_write_enable),
        .memory_read         (memory_read)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // sramc stand-in: writes land at the edge, reads return LAT cycles after the address.
    logic [31:0] sram_mem [64];
    logic [31:0] rd_pipe [LAT];
    logic        mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) sram_mem[i] <= '0;
            mem_ready <= 1'b1;
        end else if (memory_write_enable) begin
            sram_mem[memory_address[5:0]] <= memory_write;
        end
        rd_pipe[0] <= sram_mem[memory_address[5:0]];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign memory_read = rd_pipe[LAT-1];

    // Transaction-level reference: winner choice, shadow memory, queue of due reads.
    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          due;
    } rd_t;

    rd_t         pend[$];
    logic [31:0] shadow [64];
    int          cyc = 0;
    int          starve = 0;

    always @(negedge clk) begin
        int            win;
        logic [AW-1:0] ea;
        logic [31:0]   ew, ecd, eid;
        logic          ewe, ecv, eiv, rd_we;
        rd_t           item;
        if (cyc == 0) for (int i = 0; i < 64; i++) shadow[i] = '0;
        if (reset) begin
            chk("reset_grants", {cpu_grant, io_grant}, 64'd0);
            chk("reset_mem", {memory_write_enable, memory_address, memory_write}, 64'd0);
            chk("reset_rd", {cpu_rvalid, io_rvalid, cpu_rdata | io_rdata}, 64'd0);
            pend.delete();
            starve = 0;
        end else begin
            win = 0;
            if (io_req && starve == LIM) win = 2;
            else if (cpu_req) win = 1;
            else if (io_req) win = 2;
            chk("grants", {cpu_grant, io_grant}, {62'd0, win == 1, win == 2});
            ea = '0; ew = '0; ewe = 1'b0; rd_we = 1'b0;
            if (win == 1) begin ea = cpu_addr; ew = cpu_wdata; ewe = cpu_we; end
            if (win == 2) begin ea = io_addr;  ew = io_wdata;  ewe = io_we;  end
            chk("mem_drive", {memory_write_enable, memory_address, memory_write}, {ewe, ea, ew});
            ecv = 1'b0; eiv = 1'b0; ecd = '0; eid = '0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                item = pend.pop_front();
                if (item.owner == OWNER_IO) begin eiv = 1'b1; eid = item.data; end
                else begin ecv = 1'b1; ecd = item.data; end
            end
            chk("cpu_rd", {cpu_rvalid, cpu_rdata}, {ecv, ecd});
            chk("io_rd", {io_rvalid, io_rdata}, {eiv, eid});
            if (win != 0) begin
                if (ewe) shadow[ea[5:0]] = ew;
                else pend.push_back('{owner: (win == 2), data: shadow[ea[5:0]], due: cyc + LAT});
            end
            if (io_req && win != 2) starve = (starve >= LIM) ? LIM : starve + 1;
            else starve = 0;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic r, input logic we, input logic [AW-1:0] a,
                           input logic [31:0] d);
        cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_io(input logic r, input logic we, input logic [AW-1:0] a,
                          input logic [31:0] d);
        io_req = r; io_we = we; io_addr = a; io_wdata = d;
    endtask

    initial begin
        logic cg, ig;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // CPU store then load
        set_cpu(1, 1, 15, 32'h0000000A);
        @(negedge clk); chk("t1_store_grant", cpu_grant, 1);
        step(); set_cpu(0, 0, 0, 0);
        @(negedge clk); chk("t1_idle_grant", {cpu_grant, io_grant}, 0);
        step(); set_cpu(1, 0, 15, 0);
        @(negedge clk); chk("t1_load_grant", cpu_grant, 1);
        step(); set_cpu(0, 0, 0, 0);
        @(negedge clk); chk("t1_early_rvalid", cpu_rvalid, 0);
        step();
        @(negedge clk);
        chk("t1_cpu_rd", {cpu_rvalid, cpu_rdata}, {1'b1, 32'd10});
        chk("t1_io_rvalid", io_rvalid, 0);

        // I/O store then load
        step(); set_io(1, 1, 20, 32'd30);
        @(negedge clk); chk("t2_store_grant", {cpu_grant, io_grant}, 2'b01);
        step(); set_io(1, 0, 20, 0);
        @(negedge clk); chk("t2_load_grant", io_grant, 1);
        step(); set_io(0, 0, 0, 0);
        @(negedge clk);
        step();
        @(negedge clk);
        chk("t2_io_rd", {io_rvalid, io_rdata}, {1'b1, 32'd30});
        chk("t2_cpu_idle", {cpu_rvalid, cpu_grant, cpu_rdata}, 0);

        // Interleaved reads
        step(); set_cpu(1, 0, 15, 0);
        @(negedge clk); chk("t3_g0", {cpu_grant, io_grant}, 2'b10);
        step(); set_cpu(0, 0, 0, 0); set_io(1, 0, 20, 0);
        @(negedge clk); chk("t3_g1", {cpu_grant, io_grant}, 2'b01);
        step(); set_io(0, 0, 0, 0); set_cpu(1, 0, 15, 0);
        @(negedge clk);
        chk("t3_g2", {cpu_grant, io_grant}, 2'b10);
        chk("t3_r0", {cpu_rvalid, io_rvalid, cpu_rdata}, {2'b10, 32'd10});
        step(); set_cpu(0, 0, 0, 0);
        @(negedge clk); chk("t3_r1", {cpu_rvalid, io_rvalid, io_rdata}, {2'b01, 32'd30});
        step();
        @(negedge clk); chk("t3_r2", {cpu_rvalid, io_rvalid, cpu_rdata}, {2'b10, 32'd10});

        // Starvation bound with CPU requesting continuously
        step(); set_cpu(1, 0, 15, 0); set_io(1, 0, 20, 0);
        for (int k = 0; k <= LIM; k++) begin
            @(negedge clk);
            chk("t4_io_grant", io_grant, (k == LIM));
            chk("t4_cpu_grant", cpu_grant, (k != LIM));
            step();
        end
        set_io(0, 0, 0, 0);
        @(negedge clk); chk("t4_cpu_resume", {cpu_grant, io_grant}, 2'b10);
        step(); set_cpu(0, 0, 0, 0);
        repeat (3) step();

        // Reset one cycle after a CPU load grant drops the read
        set_cpu(1, 0, 15, 0);
        @(negedge clk); chk("t5_load_grant", cpu_grant, 1);
        step(); set_cpu(0, 0, 0, 0); reset = 1'b1;
        @(negedge clk); chk("t5_rst_rvalid", cpu_rvalid, 0);
        step(); reset = 1'b0;
        @(negedge clk); chk("t5_dropped0", cpu_rvalid, 0);
        step();
        @(negedge clk); chk("t5_dropped1", cpu_rvalid, 0);
        step(); set_cpu(1, 0, 15, 0);
        @(negedge clk); chk("t5_post_grant", cpu_grant, 1);
        step(); set_cpu(0, 0, 0, 0);
        @(negedge clk);
        step();
        @(negedge clk); chk("t5_post_rd", {cpu_rvalid, cpu_rdata}, {1'b1, 32'd10});

        // Idle
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            chk("t6_idle", {memory_write_enable, memory_address, cpu_rvalid, io_rvalid}, 0);
        end

        // Randomized traffic; requesters hold req and payload until granted
        cg = 1'b0; ig = 1'b0;
        for (int i = 0; i < 800; i++) begin
            step();
            reset = ($urandom_range(0, 149) == 0);
            if (!cpu_req || cg) begin
                if ($urandom_range(0, 99) < 65)
                    set_cpu(1, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 63)), $urandom);
                else
                    cpu_req = 1'b0;
            end
            if (!io_req || ig) begin
                if ($urandom_range(0, 99) < 40)
                    set_io(1, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 63)), $urandom);
                else
                    io_req = 1'b0;
            end
            @(negedge clk);
            cg = cpu_req && cpu_grant;
            ig = io_req && io_grant;
        end

        step(); reset = 1'b0; set_cpu(0, 0, 0, 0); set_io(0, 0, 0, 0);
        repeat (4) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
